// File: rtl/wb_mem_pkg.sv
// rtl/wb_mem_pkg.sv - shared constants and port FSM state for the dual-port memory
package wb_mem_pkg;

  localparam logic [31:0] NOP_INSN            = 32'h0000_0013;
  localparam int          DEFAULT_TOHOST_WORD = 1024;

  typedef enum logic [1:0] {
    PORT_IDLE,
    PORT_WAIT,
    PORT_RESP
  } port_state_t;

endpackage

// File: rtl/wb_mem_port_ctrl.sv
// rtl/wb_mem_port_ctrl.sv - per-port request FSM, wait counter and address range check
module wb_mem_port_ctrl
  import wb_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 0,
  parameter int HI_W        = 17
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cyc,
  input  logic            stb,
  input  logic [HI_W-1:0] adr_hi,
  output logic            commit,
  output logic            in_range,
  output logic            ack,
  output logic            err
);

  localparam int CW = 16;

  port_state_t   state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          err_q;
  logic          go;

  assign in_range = (adr_hi == '0);
  // An async-held reset must never let a request slip through to the array.
  assign commit   = go & rst_n;
  assign ack      = (state == PORT_RESP) & ~err_q;
  assign err      = (state == PORT_RESP) & err_q;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    go      = 1'b0;
    case (state)
      PORT_IDLE: begin
        if (cyc && stb) begin
          if (WAIT_CYCLES == 0) begin
            state_n = PORT_RESP;
            go      = 1'b1;
          end else begin
            state_n = PORT_WAIT;
            cnt_n   = CW'(WAIT_CYCLES - 1);
          end
        end
      end
      PORT_WAIT: begin
        if (!(cyc && stb)) begin
          state_n = PORT_IDLE;
        end else if (cnt == '0) begin
          state_n = PORT_RESP;
          go      = 1'b1;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      PORT_RESP: state_n = PORT_IDLE;
      default:   state_n = PORT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= PORT_IDLE;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (commit) err_q <= ~in_range;
    end
  end

endmodule

// File: rtl/wb_dual_port_mem.sv
// rtl/wb_dual_port_mem.sv - unified instruction/data Wishbone memory with tohost test monitor
module wb_dual_port_mem
  import wb_mem_pkg::*;
#(
  parameter int    ADDR_WIDTH  = 13,
  parameter int    IWAIT       = 0,
  parameter int    DWAIT       = 0,
  parameter int    TOHOST_WORD = DEFAULT_TOHOST_WORD,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] iwb_adr_i,
  input  logic        iwb_cyc_i,
  input  logic        iwb_stb_i,
  output logic [31:0] iwb_dat_o,
  output logic        iwb_ack_o,
  output logic        iwb_err_o,
  input  logic [31:0] dwb_adr_i,
  input  logic [31:0] dwb_dat_i,
  input  logic        dwb_we_i,
  input  logic [3:0]  dwb_sel_i,
  input  logic        dwb_cyc_i,
  input  logic        dwb_stb_i,
  output logic [31:0] dwb_dat_o,
  output logic        dwb_ack_o,
  output logic        dwb_err_o,
  output logic        tohost_valid_o,
  output logic [31:0] tohost_data_o,
  output logic        test_pass_o,
  output logic        test_fail_o
);

  localparam int HI_W  = 30 - ADDR_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] mem [DEPTH];

  // Unwritten words read as NOP so a stray fetch just slides forward.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = NOP_INSN;
  end

  logic [ADDR_WIDTH-1:0] i_idx, d_idx;
  logic                  i_commit, i_in_range, d_commit, d_in_range;
  logic [31:0]           i_rdata, d_rdata;
  logic                  tohost_hit;
  logic                  unused_adr_lsbs;

  assign i_idx           = iwb_adr_i[ADDR_WIDTH+1:2];
  assign d_idx           = dwb_adr_i[ADDR_WIDTH+1:2];
  assign unused_adr_lsbs = ^{iwb_adr_i[1:0], dwb_adr_i[1:0]};

  wb_mem_port_ctrl #(.WAIT_CYCLES(IWAIT), .HI_W(HI_W)) u_iport (
    .clk     (clk),
    .rst_n   (rst_n),
    .cyc     (iwb_cyc_i),
    .stb     (iwb_stb_i),
    .adr_hi  (iwb_adr_i[31:ADDR_WIDTH+2]),
    .commit  (i_commit),
    .in_range(i_in_range),
    .ack     (iwb_ack_o),
    .err     (iwb_err_o)
  );

  wb_mem_port_ctrl #(.WAIT_CYCLES(DWAIT), .HI_W(HI_W)) u_dport (
    .clk     (clk),
    .rst_n   (rst_n),
    .cyc     (dwb_cyc_i),
    .stb     (dwb_stb_i),
    .adr_hi  (dwb_adr_i[31:ADDR_WIDTH+2]),
    .commit  (d_commit),
    .in_range(d_in_range),
    .ack     (dwb_ack_o),
    .err     (dwb_err_o)
  );

  // Non-blocking update means a same-edge fetch samples the pre-write word.
  always @(posedge clk) begin
    if (d_commit && d_in_range && dwb_we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (dwb_sel_i[b]) mem[d_idx][8*b +: 8] <= dwb_dat_i[8*b +: 8];
      end
    end
  end

  assign tohost_hit = d_commit && d_in_range && dwb_we_i &&
                      (d_idx == ADDR_WIDTH'(TOHOST_WORD)) && (dwb_dat_i != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_rdata        <= '0;
      d_rdata        <= '0;
      tohost_valid_o <= 1'b0;
      tohost_data_o  <= '0;
      test_pass_o    <= 1'b0;
      test_fail_o    <= 1'b0;
    end else begin
      if (i_commit) i_rdata <= i_in_range ? mem[i_idx] : '0;
      if (d_commit) d_rdata <= d_in_range ? mem[d_idx] : '0;
      tohost_valid_o <= tohost_hit;
      if (tohost_hit) begin
        tohost_data_o <= dwb_dat_i;
        if (dwb_dat_i == 32'd1) test_pass_o <= 1'b1;
        else                    test_fail_o <= 1'b1;
      end
    end
  end

  assign iwb_dat_o = iwb_ack_o ? i_rdata : '0;
  assign dwb_dat_o = dwb_ack_o ? d_rdata : '0;

endmodule

// File: tb/tb_wb_dual_port_mem.sv
// tb/tb_wb_dual_port_mem.sv - scoreboard bench for wb_dual_port_mem
module tb_wb_dual_port_mem;

  localparam int IWAIT = 0;
  localparam int DWAIT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] iwb_adr_i, iwb_dat_o;
  logic        iwb_cyc_i, iwb_stb_i, iwb_ack_o, iwb_err_o;
  logic [31:0] dwb_adr_i, dwb_dat_i, dwb_dat_o;
  logic        dwb_we_i, dwb_cyc_i, dwb_stb_i, dwb_ack_o, dwb_err_o;
  logic [3:0]  dwb_sel_i;
  logic        tohost_valid_o, test_pass_o, test_fail_o;
  logic [31:0] tohost_data_o;

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] model [int];
  logic [31:0] exp_q [$];
  logic        seen_tohost;

  always #5 clk = ~clk;

  wb_dual_port_mem #(
    .ADDR_WIDTH(13), .IWAIT(IWAIT), .DWAIT(DWAIT), .TOHOST_WORD(1024), .INIT_FILE("")
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .iwb_adr_i(iwb_adr_i), .iwb_cyc_i(iwb_cyc_i), .iwb_stb_i(iwb_stb_i),
    .iwb_dat_o(iwb_dat_o), .iwb_ack_o(iwb_ack_o), .iwb_err_o(iwb_err_o),
    .dwb_adr_i(dwb_adr_i), .dwb_dat_i(dwb_dat_i), .dwb_we_i(dwb_we_i),
    .dwb_sel_i(dwb_sel_i), .dwb_cyc_i(dwb_cyc_i), .dwb_stb_i(dwb_stb_i),
    .dwb_dat_o(dwb_dat_o), .dwb_ack_o(dwb_ack_o), .dwb_err_o(dwb_err_o),
    .tohost_valid_o(tohost_valid_o), .tohost_data_o(tohost_data_o),
    .test_pass_o(test_pass_o), .test_fail_o(test_fail_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mread(input int idx);
    return model.exists(idx) ? model[idx] : 32'h0000_0013;
  endfunction

  task automatic mwrite(input int idx, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] w;
    w = mread(idx);
    for (int b = 0; b < 4; b++) if (sel[b]) w[8*b +: 8] = dat[8*b +: 8];
    model[idx] = w;
  endtask

  function automatic bit oor(input logic [31:0] adr);
    return adr[31:15] != '0;
  endfunction

  task automatic d_xfer(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                        input logic we, input logic [3:0] sel);
    int          lat;
    logic [31:0] exp;
    exp_q.push_back(oor(adr) ? 32'h0 : mread(int'(adr[14:2])));
    if (we && !oor(adr)) mwrite(int'(adr[14:2]), dat, sel);
    dwb_adr_i = adr; dwb_dat_i = dat; dwb_we_i = we; dwb_sel_i = sel;
    dwb_cyc_i = 1'b1; dwb_stb_i = 1'b1;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!(dwb_ack_o || dwb_err_o) && lat < 20);
    seen_tohost = tohost_valid_o;
    exp = exp_q.pop_front();
    chk($sformatf("%s_lat", tag), 32'(lat), 32'(DWAIT + 1));
    chk($sformatf("%s_ackerr", tag), 32'({dwb_ack_o, dwb_err_o}), oor(adr) ? 32'd1 : 32'd2);
    if (!we) chk($sformatf("%s_dat", tag), dwb_dat_o, exp);
    dwb_cyc_i = 1'b0; dwb_stb_i = 1'b0; dwb_we_i = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("%s_onecyc", tag), 32'({dwb_ack_o, dwb_err_o}), 32'd0);
  endtask

  task automatic i_fetch(input string tag, input logic [31:0] adr);
    int lat;
    exp_q.push_back(mread(int'(adr[14:2])));
    iwb_adr_i = adr; iwb_cyc_i = 1'b1; iwb_stb_i = 1'b1;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!(iwb_ack_o || iwb_err_o) && lat < 20);
    chk($sformatf("%s_lat", tag), 32'(lat), 32'(IWAIT + 1));
    chk($sformatf("%s_dat", tag), iwb_dat_o, exp_q.pop_front());
    iwb_cyc_i = 1'b0; iwb_stb_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] old;
    int          acks;
    rst_n = 1'b0;
    iwb_adr_i = '0; iwb_cyc_i = 1'b0; iwb_stb_i = 1'b0;
    dwb_adr_i = '0; dwb_dat_i = '0; dwb_we_i = 1'b0; dwb_sel_i = '0;
    dwb_cyc_i = 1'b0; dwb_stb_i = 1'b0;
    #3;
    chk("reset_flags", 32'({iwb_ack_o, iwb_err_o, dwb_ack_o, dwb_err_o,
                            tohost_valid_o, test_pass_o, test_fail_o}), 32'd0);
    chk("reset_data", iwb_dat_o | dwb_dat_o | tohost_data_o, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Image word 0 and a preloaded data word.
    d_xfer("load_w0", 32'h0000_0000, 32'h0050_0093, 1'b1, 4'hF);
    i_fetch("fetch_w0", 32'h0000_0000);
    i_fetch("fetch_nop", 32'h0000_001C);
    d_xfer("load_100", 32'h0000_0100, 32'h1122_3344, 1'b1, 4'hF);
    d_xfer("sel0101_wr", 32'h0000_0100, 32'hAABB_CCDD, 1'b1, 4'b0101);
    d_xfer("sel0101_rd", 32'h0000_0100, 32'h0, 1'b0, 4'hF);
    chk("sel0101_model", mread(32'h40), 32'h11BB_33DD);
    d_xfer("sel0_wr", 32'h0000_0100, 32'hFFFF_FFFF, 1'b1, 4'b0000);
    d_xfer("lsb_ignore_rd", 32'h0000_0103, 32'h0, 1'b0, 4'hF);

    // Same-edge data write and fetch of word 5.
    old = mread(5);
    dwb_adr_i = 32'h14; dwb_dat_i = 32'hDEAD_BEEF; dwb_we_i = 1'b1; dwb_sel_i = 4'hF;
    dwb_cyc_i = 1'b1; dwb_stb_i = 1'b1;
    mwrite(5, 32'hDEAD_BEEF, 4'hF);
    repeat (3) begin @(posedge clk); #1; end
    iwb_adr_i = 32'h14; iwb_cyc_i = 1'b1; iwb_stb_i = 1'b1;
    @(posedge clk); #1;
    chk("same_cyc_acks", 32'({iwb_ack_o, dwb_ack_o}), 32'd3);
    chk("same_cyc_old", iwb_dat_o, old);
    iwb_cyc_i = 1'b0; iwb_stb_i = 1'b0; dwb_cyc_i = 1'b0; dwb_stb_i = 1'b0; dwb_we_i = 1'b0;
    @(posedge clk); #1;
    i_fetch("fetch_new", 32'h0000_0014);

    // Out-of-range accesses alias word 0 in the low bits but must not touch it.
    d_xfer("oor_rd", 32'h0001_0000, 32'h0, 1'b0, 4'hF);
    d_xfer("oor_wr", 32'h0001_0000, 32'h5555_5555, 1'b1, 4'hF);
    d_xfer("oor_w0_chk", 32'h0000_0000, 32'h0, 1'b0, 4'hF);

    // Strobe dropped on the second wait cycle of a write.
    dwb_adr_i = 32'h140; dwb_dat_i = 32'h0000_0055; dwb_we_i = 1'b1; dwb_sel_i = 4'hF;
    dwb_cyc_i = 1'b1; dwb_stb_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    dwb_stb_i = 1'b0;
    acks = 0;
    repeat (6) begin @(posedge clk); #1; if (dwb_ack_o || dwb_err_o) acks++; end
    chk("abort_no_ack", 32'(acks), 32'd0);
    dwb_cyc_i = 1'b0; dwb_we_i = 1'b0;
    @(posedge clk); #1;
    d_xfer("abort_no_wr", 32'h0000_0140, 32'h0, 1'b0, 4'hF);

    // Reset during the wait phase of a write.
    dwb_adr_i = 32'h180; dwb_dat_i = 32'h1234_5678; dwb_we_i = 1'b1; dwb_sel_i = 4'hF;
    dwb_cyc_i = 1'b1; dwb_stb_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_flags", 32'({iwb_ack_o, iwb_err_o, dwb_ack_o, dwb_err_o,
                              tohost_valid_o, test_pass_o, test_fail_o}), 32'd0);
    chk("rst_mid_data", iwb_dat_o | dwb_dat_o | tohost_data_o, 32'd0);
    @(posedge clk); #1;
    dwb_cyc_i = 1'b0; dwb_stb_i = 1'b0; dwb_we_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    d_xfer("rst_no_wr", 32'h0000_0180, 32'h0, 1'b0, 4'hF);

    // tohost pass run.
    d_xfer("tohost_pass", 32'h0000_1000, 32'h0000_0001, 1'b1, 4'hF);
    chk("tohost_pass_valid", 32'(seen_tohost), 32'd1);
    chk("tohost_pulse_end", 32'(tohost_valid_o), 32'd0);
    chk("tohost_pass_flags", 32'({test_pass_o, test_fail_o}), 32'd2);
    chk("tohost_pass_data", tohost_data_o, 32'd1);

    // Fresh run: zero write is silent, then a fail code.
    pulse_reset();
    chk("fresh_flags", 32'({test_pass_o, test_fail_o}), 32'd0);
    d_xfer("tohost_zero", 32'h0000_1000, 32'h0000_0000, 1'b1, 4'hF);
    chk("tohost_zero_valid", 32'(seen_tohost), 32'd0);
    chk("tohost_zero_data", tohost_data_o, 32'd0);
    d_xfer("tohost_fail", 32'h0000_1000, 32'h0000_0007, 1'b1, 4'hF);
    chk("tohost_fail_valid", 32'(seen_tohost), 32'd1);
    chk("tohost_fail_flags", 32'({test_pass_o, test_fail_o}), 32'd1);
    chk("tohost_fail_code", tohost_data_o >> 1, 32'd3);
    d_xfer("tohost_mem", 32'h0000_1000, 32'h0, 1'b0, 4'hF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
